// File: rtl/rf_pkg.sv
// Shared types and default sizes for the operand fetch stage.
package rf_pkg;

  localparam int unsigned DefBusWidth = 8;
  localparam int unsigned DefDepth    = 8;
  localparam int unsigned DefOpWidth  = 16;
  localparam int unsigned DefAddrW    = $clog2(DefDepth);

  // Passthrough payload captured on accept and presented to execute.
  typedef struct packed {
    logic [DefAddrW-1:0]   rd;
    logic                  rd_en;
    logic [DefOpWidth-1:0] op;
  } hold_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per GPR, set on issue, cleared on writeback.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] look_a_idx_i,
  input  logic [ADDR_W-1:0] look_b_idx_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  logic [DEPTH-1:0] pend_q, pend_d;

  // Clear first so a same-index set in the same cycle wins.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
    if (set_en_i) pend_d[set_idx_i] = 1'b1;
  end

  // Lookups see the current vector; a writeback this cycle releases the index.
  always_comb begin
    busy_a_o = pend_q[look_a_idx_i] && !(clr_en_i && (clr_idx_i == look_a_idx_i));
    busy_b_o = pend_q[look_b_idx_i] && !(clr_en_i && (clr_idx_i == look_b_idx_i));
  end

  // Pending vector state.
  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives the GPR array ports, bypasses writeback data over
// the synchronous read, and stalls issue on pending destination writes.
// The hold register uses rf_pkg::hold_t, so DEPTH/OP_WIDTH overrides must match
// the package defaults.
module operand_fetch
  import rf_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DefBusWidth,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned OP_WIDTH  = DefOpWidth,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_rs_a,
  input  logic [ADDR_W-1:0]    in_rs_b,
  input  logic [ADDR_W-1:0]    in_rd,
  input  logic                 in_rd_en,
  input  logic [OP_WIDTH-1:0]  in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_a,
  output logic [BUS_WIDTH-1:0] out_b,
  output logic [ADDR_W-1:0]    out_rd,
  output logic                 out_rd_en,
  output logic [OP_WIDTH-1:0]  out_op,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [BUS_WIDTH-1:0] wb_data,
  output logic                 rf_we,
  output logic [ADDR_W-1:0]    rf_wr_addr,
  output logic [BUS_WIDTH-1:0] rf_wr_data,
  output logic [ADDR_W-1:0]    rf_rd_addr_a,
  output logic [ADDR_W-1:0]    rf_rd_addr_b,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_a,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_b
);

  hold_t                hold_q, hold_d;
  logic [ADDR_W-1:0]    held_rs_a_q, held_rs_a_d;
  logic [ADDR_W-1:0]    held_rs_b_q, held_rs_b_d;
  logic                 out_valid_q, out_valid_d;
  logic                 byp_a_q, byp_a_d, byp_b_q, byp_b_d;
  logic [BUS_WIDTH-1:0] byp_data_a_q, byp_data_a_d, byp_data_b_q, byp_data_b_d;
  logic                 busy_a, busy_b, hazard, accept;

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_en_i     (accept && in_rd_en),
    .set_idx_i    (in_rd),
    .clr_en_i     (wb_we),
    .clr_idx_i    (wb_addr),
    .look_a_idx_i (in_rs_a),
    .look_b_idx_i (in_rs_b),
    .busy_a_o     (busy_a),
    .busy_b_o     (busy_b)
  );

  // Handshake: stall on a pending source or a full, blocked output register.
  always_comb begin
    hazard   = busy_a || busy_b;
    in_ready = (!out_valid_q || out_ready) && !hazard && !rst;
    accept   = in_valid && in_ready;
  end

  // GPR port drive; the held sources are re-read every cycle while stalled.
  always_comb begin
    rf_we        = wb_we;
    rf_wr_addr   = wb_addr;
    rf_wr_data   = wb_data;
    rf_rd_addr_a = accept ? in_rs_a : held_rs_a_q;
    rf_rd_addr_b = accept ? in_rs_b : held_rs_b_q;
  end

  // Next state: capture on accept, bypass any write that races the array read.
  always_comb begin
    hold_d       = hold_q;
    held_rs_a_d  = held_rs_a_q;
    held_rs_b_d  = held_rs_b_q;
    out_valid_d  = out_valid_q;
    if (accept) begin
      hold_d      = '{rd: in_rd, rd_en: in_rd_en, op: in_op};
      held_rs_a_d = in_rs_a;
      held_rs_b_d = in_rs_b;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    byp_a_d      = wb_we && (wb_addr == rf_rd_addr_a);
    byp_b_d      = wb_we && (wb_addr == rf_rd_addr_b);
    byp_data_a_d = wb_data;
    byp_data_b_d = wb_data;
  end

  // Stage registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q       <= '0;
      held_rs_a_q  <= '0;
      held_rs_b_q  <= '0;
      out_valid_q  <= 1'b0;
      byp_a_q      <= 1'b0;
      byp_b_q      <= 1'b0;
      byp_data_a_q <= '0;
      byp_data_b_q <= '0;
    end else begin
      hold_q       <= hold_d;
      held_rs_a_q  <= held_rs_a_d;
      held_rs_b_q  <= held_rs_b_d;
      out_valid_q  <= out_valid_d;
      byp_a_q      <= byp_a_d;
      byp_b_q      <= byp_b_d;
      byp_data_a_q <= byp_data_a_d;
      byp_data_b_q <= byp_data_b_d;
    end
  end

  // Output view of the stage register.
  always_comb begin
    out_valid = out_valid_q;
    out_rd    = hold_q.rd;
    out_rd_en = hold_q.rd_en;
    out_op    = hold_q.op;
    out_a     = byp_a_q ? byp_data_a_q : rf_rd_data_a;
    out_b     = byp_b_q ? byp_data_b_q : rf_rd_data_b;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read pipeline stage between instruction decode and execute. It drives the read and write ports of the dual-port GPR array, whose reads are synchronous with one cycle of latency. It resolves read-during-write collisions by bypass and tracks pending destination writes in a scoreboard so that no dependent instruction issues early. Operands and the passthrough payload are presented to execute through a valid/ready output register.

## Interface
- BUS_WIDTH, 8, GPR data width
- DEPTH, 8, number of GPRs; ADDR_W = $clog2(DEPTH)
- OP_WIDTH, 16, opaque decoded-op payload width, passed through unchanged
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid / in_ready  in / out  1  decode handshake
- in_rs_a, in_rs_b  in  ADDR_W  source register indices
- in_rd  in  ADDR_W  destination index; in_rd_en  in  1  instruction writes in_rd
- in_op  in  OP_WIDTH  payload
- out_valid / out_ready  out / in  1  execute handshake
- out_a, out_b  out  BUS_WIDTH  operand values
- out_rd, out_rd_en, out_op  out  as inputs  registered passthrough
- wb_we, wb_addr, wb_data  in  1 / ADDR_W / BUS_WIDTH  writeback request
- rf_we, rf_wr_addr, rf_wr_data  out  to GPR write port; combinational copy of wb_*
- rf_rd_addr_a, rf_rd_addr_b  out  ADDR_W  to GPR read ports
- rf_rd_data_a, rf_rd_data_b  in  BUS_WIDTH  GPR read data, valid one cycle after address

## Operation
- hazard = (pend[in_rs_a] && !(wb_we && wb_addr==in_rs_a)) || (same for in_rs_b); computed regardless of in_valid.
- in_ready = (!out_valid || out_ready) && !hazard. accept = in_valid && in_ready.
- On accept: capture in_rs_a/b, in_rd, in_rd_en, in_op into hold regs; out_valid<=1. Else if out_ready: out_valid<=0.
- Read address: rf_rd_addr_x = accept ? in_rs_x : held_rs_x. Array is re-read every cycle, so a stalled output always reflects current contents.
- Bypass per operand: byp_x <= wb_we && wb_addr==rf_rd_addr_x; byp_data_x <= wb_data. out_x = byp_x ? byp_data_x : rf_rd_data_x. This covers read-during-write, because the array returns old data.
- Scoreboard pend[DEPTH-1:0]:
  - set pend[in_rd] on accept with in_rd_en.
  - clear pend[wb_addr] on wb_we.
  - Same index set and cleared in one cycle: set wins.
  - Hazard is checked before set, so an instruction whose in_rd equals its own rs does not stall on itself.
- Writes to any index, including 0, are ordinary; no hardwired zero register.
- Out-of-order writeback to an index with two pending producers is not supported. Decode must not issue a second writer while pend[rd] is set; the block stalls on the rd-as-source case only.

## Timing
- Reset values:
  - out_valid=0; out_rd=0, out_rd_en=0, out_op=0.
  - held_rs_a/b=0, byp_a/b=0, pend=0.
  - out_a/out_b are don't-care while out_valid=0.
- Latency: accept at edge N, out_valid=1 with correct operands from cycle N+1.
- Throughput: one instruction per cycle when out_ready=1 and no hazard.
- Writeback in the accept cycle to the same rs: value appears via bypass at N+1.
- Writeback during stall: a write at cycle K is visible on out_x at K+1 and remains visible afterwards.
- rst mid-operation drops the held instruction and all pending bits in the same edge. in_ready is low during the reset cycle.
- rf_* write outputs have zero latency from wb_*.

## Structure
- Package rf_pkg:
  - BUS_WIDTH and DEPTH defaults, plus the ADDR_W localparam expression.
  - Struct of {rd, rd_en, op} for the hold register.
- Sub-module rf_scoreboard: pend vector with set/clear ports, set-wins priority, and two lookup ports with wb-clear bypass.

## Test plan
- Reset, then r3 written with 0x5A via wb; next cycle issue rs_a=3 -> out_a=0x5A one cycle after accept, out_valid=1.
- Issue rs_a=2 with wb_we to r2=0x11 in the same cycle (array held 0x00) -> out_a=0x11 via bypass.
- out_ready=0 for 4 cycles holding rs_b=4; wb r4=0x77 in cycle 2 -> out_b=0x77 from cycle 3, out_valid stays 1, in_ready=0.
- Accept rd=5 rd_en=1, then issue rs_a=5 -> in_ready=0 until wb r5=0x33. Accept happens in the wb cycle and out_a=0x33.
- Back-to-back 8 instructions, out_ready=1, no hazards -> 8 outputs on 8 consecutive cycles, payload order preserved.
- Assert rst while out_valid=1 and pend[5]=1 -> next cycle out_valid=0, pend=0, and rs_a=5 is accepted immediately.
